// File: rtl/pll_speed_ctrl_if.sv
// Avalon-MM management bus between the speed controller and the pll_cfg reconfiguration block.
// Latency: none, pure signal bundle.
// Backpressure: slave stretches any write by holding mgmt_waitrequest high.
interface pll_speed_ctrl_if;
   logic        mgmt_write;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        mgmt_waitrequest;

   // Controller side drives the transfer, pll_cfg answers with waitrequest
   modport master (
      output mgmt_write,
      output mgmt_address,
      output mgmt_writedata,
      input  mgmt_waitrequest
   );

   modport slave (
      input  mgmt_write,
      input  mgmt_address,
      input  mgmt_writedata,
      output mgmt_waitrequest
   );
endinterface

// File: rtl/pll_speed_ctrl.sv
// Filters the requested speed profile and reprograms pll_cfg (mode, K, start), then waits for relock.
// Latency: WR_MODE starts 3+STABLE_CYCLES cycles after a profile input edge; hold drops SETTLE_CYCLES after relock.
// Backpressure: each write is held with stable address/data for as long as mgmt_waitrequest is high.
module pll_speed_ctrl #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES    = 3,
   parameter int unsigned LOCK_TIMEOUT  = 65535,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter logic [31:0] K_NATIVE      = 32'd3639383488,
   parameter logic [31:0] K_UNDER       = 32'd2971430088,
   parameter logic [31:0] K_BOOT        = 32'd2748778984
) (
   input  logic                 clk_50m,
   input  logic                 reset,
   input  logic                 underclock,
   input  logic                 bootleg,
   input  logic                 pll_locked,
   pll_speed_ctrl_if.master     mgmt,
   output logic                 busy,
   output logic                 core_hold,
   output logic                 lock_error,
   output logic [1:0]           active_profile
);

   typedef enum logic [3:0] {
      IDLE, WR_MODE, GAP1, WR_K, GAP2, WR_START, WAIT_UNLOCK, WAIT_LOCK, SETTLE
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [1:0]  uc_sync;
   logic [1:0]  bl_sync;
   logic [1:0]  lk_sync;
   logic        lock_s;

   logic [1:0]  target;
   logic [1:0]  cand;
   logic [31:0] stab_cnt;
   logic [1:0]  filt;
   logic        pending;

   logic [1:0]  req;
   logic [31:0] step_cnt;
   logic        gap_done;
   logic        wait_expired;
   logic        settle_done;
   logic [31:0] k_word;

   assign lock_s       = lk_sync[1];
   assign target       = bl_sync[1] ? 2'd2 : (uc_sync[1] ? 2'd1 : 2'd0);
   assign pending      = (filt != active_profile);
   assign gap_done     = (step_cnt == GAP_CYCLES - 1);
   assign wait_expired = (step_cnt == LOCK_TIMEOUT - 1);
   assign settle_done  = (step_cnt == SETTLE_CYCLES - 1);

   // Two-flop synchronizers for the asynchronous level inputs
   always_ff @(posedge clk_50m) begin
      if (reset) begin
         uc_sync <= 2'b00;
         bl_sync <= 2'b00;
         lk_sync <= 2'b00;
      end else begin
         uc_sync <= {uc_sync[0], underclock};
         bl_sync <= {bl_sync[0], bootleg};
         lk_sync <= {lk_sync[0], pll_locked};
      end
   end

   // Debounce the target: accept it only after STABLE_CYCLES identical samples
   always_ff @(posedge clk_50m) begin
      if (reset) begin
         cand     <= 2'd0;
         stab_cnt <= 32'd0;
         filt     <= 2'd0;
      end else if (target != cand) begin
         cand     <= target;
         stab_cnt <= 32'd1;
      end else begin
         if (stab_cnt < STABLE_CYCLES) begin
            stab_cnt <= stab_cnt + 32'd1;
         end
         if (stab_cnt == STABLE_CYCLES - 1) begin
            filt <= cand;
         end
      end
   end

   // State register
   always_ff @(posedge clk_50m) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: writes advance on a cycle without waitrequest, waits advance on lock edge or timeout
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:        if (pending)                       state_nxt = WR_MODE;
         WR_MODE:     if (!mgmt.mgmt_waitrequest)        state_nxt = GAP1;
         GAP1:        if (gap_done)                      state_nxt = WR_K;
         WR_K:        if (!mgmt.mgmt_waitrequest)        state_nxt = GAP2;
         GAP2:        if (gap_done)                      state_nxt = WR_START;
         WR_START:    if (!mgmt.mgmt_waitrequest)        state_nxt = WAIT_UNLOCK;
         WAIT_UNLOCK: if (!lock_s || wait_expired)       state_nxt = WAIT_LOCK;
         WAIT_LOCK:   if (lock_s || wait_expired)        state_nxt = SETTLE;
         SETTLE:      if (settle_done)                   state_nxt = IDLE;
         default:                                        state_nxt = IDLE;
      endcase
   end

   // Per-state step counter, request latch, sticky timeout flag and applied profile
   always_ff @(posedge clk_50m) begin
      if (reset) begin
         step_cnt       <= 32'd0;
         req            <= 2'd0;
         lock_error     <= 1'b0;
         active_profile <= 2'd0;
      end else begin
         if (state == IDLE || state_nxt != state) begin
            step_cnt <= 32'd0;
         end else begin
            step_cnt <= step_cnt + 32'd1;
         end
         if (state == IDLE && pending) begin
            req <= filt;
         end
         if ((state == WAIT_UNLOCK && lock_s && wait_expired) ||
             (state == WAIT_LOCK && !lock_s && wait_expired)) begin
            lock_error <= 1'b1;
         end
         if (state == SETTLE && settle_done) begin
            active_profile <= req;
         end
      end
   end

   // K word for the latched request
   always_comb begin
      unique case (req)
         2'd2:    k_word = K_BOOT;
         2'd1:    k_word = K_UNDER;
         default: k_word = K_NATIVE;
      endcase
   end

   // Outputs decoded from state; bus returns to zero outside the write states
   always_comb begin
      mgmt.mgmt_write     = 1'b0;
      mgmt.mgmt_address   = 6'd0;
      mgmt.mgmt_writedata = 32'd0;
      busy                = (state != IDLE);
      core_hold           = (state != IDLE);
      case (state)
         WR_MODE: begin
            mgmt.mgmt_write = 1'b1;
         end
         WR_K: begin
            mgmt.mgmt_write     = 1'b1;
            mgmt.mgmt_address   = 6'd7;
            mgmt.mgmt_writedata = k_word;
         end
         WR_START: begin
            mgmt.mgmt_write   = 1'b1;
            mgmt.mgmt_address = 6'd2;
         end
         default: begin
            mgmt.mgmt_write = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_speed_ctrl.sv
// Bench for pll_speed_ctrl: table of profile requests plus hand sequences for glitch, busy change, timeout, reset.
// Latency: expected write schedule and relock timing are derived from the parameters below.
// Backpressure: a waitrequest driver stalls the K write for a per-vector number of cycles.
module tb_pll_speed_ctrl;
   localparam int unsigned STABLE = 4;
   localparam int unsigned GAP    = 3;
   localparam int unsigned TMO    = 16;
   localparam int unsigned SETTLE = 32;
   localparam logic [31:0] KN = 32'd3639383488;
   localparam logic [31:0] KU = 32'd2971430088;
   localparam logic [31:0] KB = 32'd2748778984;

   logic       clk_50m = 1'b0;
   logic       reset;
   logic       underclock;
   logic       bootleg;
   logic       pll_locked;
   logic       busy;
   logic       core_hold;
   logic       lock_error;
   logic [1:0] active_profile;

   pll_speed_ctrl_if bus();

   pll_speed_ctrl #(
      .STABLE_CYCLES(STABLE), .GAP_CYCLES(GAP), .LOCK_TIMEOUT(TMO), .SETTLE_CYCLES(SETTLE),
      .K_NATIVE(KN), .K_UNDER(KU), .K_BOOT(KB)
   ) dut (
      .clk_50m(clk_50m), .reset(reset), .underclock(underclock), .bootleg(bootleg),
      .pll_locked(pll_locked), .mgmt(bus), .busy(busy), .core_hold(core_hold),
      .lock_error(lock_error), .active_profile(active_profile)
   );

   always #5 clk_50m = ~clk_50m;

   int cyc = 0;
   always @(posedge clk_50m) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(string name, longint act, longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
      int          len;
   } wr_t;

   wr_t exp_q[$];

   task automatic push_seq(input logic [31:0] k, input int stall);
      exp_q.push_back('{addr: 6'd0, data: 32'd0, len: 1});
      exp_q.push_back('{addr: 6'd7, data: k,     len: 1 + stall});
      exp_q.push_back('{addr: 6'd2, data: 32'd0, len: 1});
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_50m);
         #1;
      end
   endtask

   // Bus monitor: completed writes are popped from the scoreboard and compared
   logic        in_wr = 1'b0;
   int          wr_len;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   int          wr_start;
   int          n_done = 0;
   int          mode_start = -1;
   int          k_start = -1;
   int          go_start = -1;
   int          go_edge = -1;
   int          go_cnt = 0;
   wr_t         mon_e;

   always @(negedge clk_50m) begin
      if (bus.mgmt_write === 1'b1) begin
         if (!in_wr) begin
            in_wr    = 1'b1;
            wr_len   = 0;
            wr_addr  = bus.mgmt_address;
            wr_data  = bus.mgmt_writedata;
            wr_start = cyc;
         end else begin
            check("stall_addr_stable", bus.mgmt_address, wr_addr);
            check("stall_data_stable", bus.mgmt_writedata, wr_data);
         end
         wr_len++;
         if (bus.mgmt_waitrequest == 1'b0) begin
            in_wr = 1'b0;
            n_done++;
            check("write_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("write_addr", wr_addr, mon_e.addr);
               check("write_data", wr_data, mon_e.data);
               check("write_len", wr_len, mon_e.len);
            end
            case (wr_addr)
               6'd0: mode_start = wr_start;
               6'd7: k_start = wr_start;
               6'd2: begin
                  go_start = wr_start;
                  go_edge  = cyc + 1;
                  go_cnt++;
               end
               default: ;
            endcase
         end
      end else begin
         in_wr = 1'b0;
      end
   end

   // Slave model: stall the K write for stall_budget cycles
   int stall_budget = 0;
   initial begin
      bus.mgmt_waitrequest = 1'b0;
      forever begin
         @(posedge clk_50m);
         #1;
         if (stall_budget > 0 && bus.mgmt_write === 1'b1 && bus.mgmt_address == 6'd7) begin
            bus.mgmt_waitrequest = 1'b1;
            stall_budget--;
         end else begin
            bus.mgmt_waitrequest = 1'b0;
         end
      end
   end

   // PLL model: after each start write, lose lock 10 cycles then relock
   bit pll_auto = 1'b1;
   int relock_cyc = -1;
   int pll_seen = 0;
   initial begin
      pll_locked = 1'b1;
      forever begin
         @(posedge clk_50m);
         #1;
         if (go_cnt != pll_seen) begin
            pll_seen = go_cnt;
            if (pll_auto) begin
               pll_locked = 1'b0;
               repeat (10) begin
                  @(posedge clk_50m);
                  #1;
               end
               pll_locked = 1'b1;
               relock_cyc = cyc;
            end
         end
      end
   end

   task automatic wait_profile(input logic [1:0] p, input string name, output int at, output logic hold_before);
      logic prev;
      at = -1;
      hold_before = 1'b0;
      for (int n = 0; n < 600; n++) begin
         prev = core_hold;
         tick();
         if (active_profile == p) begin
            at = cyc;
            hold_before = prev;
            break;
         end
      end
      check({name, "_profile"}, active_profile, p);
   endtask

   task automatic quiet(input int n, output logic any_busy);
      any_busy = 1'b0;
      repeat (n) begin
         tick();
         if (busy !== 1'b0) any_busy = 1'b1;
      end
   endtask

   typedef struct {
      logic        uc;
      logic        bl;
      int          stall;
      logic [1:0]  prof;
      logic [31:0] k;
      logic        change;
   } vec_t;

   vec_t vecs[4];

   // Latency from input drive to WR_MODE: 2 sync + STABLE filter + 1 request cycle
   localparam int LAT = 2 + STABLE + 1;

   initial begin
      int   drive;
      int   at;
      int   at1;
      int   err_cyc;
      int   base;
      logic hb;
      logic any_busy;

      vecs[0] = '{uc: 1'b1, bl: 1'b0, stall: 0, prof: 2'd1, k: KU, change: 1'b1};
      vecs[1] = '{uc: 1'b1, bl: 1'b1, stall: 5, prof: 2'd2, k: KB, change: 1'b1};
      vecs[2] = '{uc: 1'b0, bl: 1'b1, stall: 0, prof: 2'd2, k: KB, change: 1'b0};
      vecs[3] = '{uc: 1'b0, bl: 1'b0, stall: 2, prof: 2'd0, k: KN, change: 1'b1};

      reset = 1'b1;
      underclock = 1'b0;
      bootleg = 1'b0;
      tick(3);
      check("rst_write", bus.mgmt_write, 0);
      check("rst_addr", bus.mgmt_address, 0);
      check("rst_data", bus.mgmt_writedata, 0);
      check("rst_busy", busy, 0);
      check("rst_hold", core_hold, 0);
      check("rst_lock_error", lock_error, 0);
      check("rst_profile", active_profile, 0);
      reset = 1'b0;

      quiet(40, any_busy);
      check("idle_busy", any_busy, 0);
      check("idle_profile", active_profile, 0);
      check("idle_lock_error", lock_error, 0);

      for (int i = 0; i < 4; i++) begin
         underclock = vecs[i].uc;
         bootleg = vecs[i].bl;
         stall_budget = vecs[i].stall;
         drive = cyc;
         if (vecs[i].change) begin
            push_seq(vecs[i].k, vecs[i].stall);
            wait_profile(vecs[i].prof, $sformatf("v%0d", i), at, hb);
            check($sformatf("v%0d_mode_latency", i), mode_start - drive, LAT);
            check($sformatf("v%0d_k_offset", i), k_start - mode_start, 1 + GAP);
            check($sformatf("v%0d_start_offset", i), go_start - mode_start, 2 + 2 * GAP + vecs[i].stall);
            check($sformatf("v%0d_settle", i), at - relock_cyc, 3 + SETTLE);
            check($sformatf("v%0d_hold_before", i), hb, 1);
            check($sformatf("v%0d_hold_after", i), core_hold, 0);
            check($sformatf("v%0d_busy_after", i), busy, 0);
         end else begin
            quiet(40, any_busy);
            check($sformatf("v%0d_no_busy", i), any_busy, 0);
            check($sformatf("v%0d_profile", i), active_profile, vecs[i].prof);
         end
      end

      // Short pulse must be rejected by the filter
      underclock = 1'b1;
      tick(2);
      underclock = 1'b0;
      quiet(40, any_busy);
      check("glitch_no_busy", any_busy, 0);
      check("glitch_profile", active_profile, 0);

      // Change request arriving in WAIT_LOCK runs as a second sequence right after the first
      underclock = 1'b1;
      push_seq(KU, 0);
      for (int n = 0; n < 200 && pll_locked !== 1'b0; n++) tick();
      check("busy_change_unlocked", pll_locked, 0);
      tick(5);
      underclock = 1'b0;
      push_seq(KN, 0);
      wait_profile(2'd1, "busy_first", at1, hb);
      wait_profile(2'd0, "busy_second", at, hb);
      check("busy_second_start", mode_start - at1, 1);

      // Lock stuck high: WAIT_UNLOCK times out, sequence still completes
      pll_auto = 1'b0;
      underclock = 1'b1;
      push_seq(KU, 0);
      err_cyc = -1;
      for (int n = 0; n < 300; n++) begin
         tick();
         if (lock_error === 1'b1) begin
            err_cyc = cyc;
            break;
         end
      end
      check("tmo_lock_error_set", lock_error, 1);
      check("tmo_error_time", err_cyc - go_edge, TMO);
      wait_profile(2'd1, "tmo", at, hb);
      check("tmo_complete_time", at - go_edge, TMO + 1 + SETTLE);
      tick(20);
      check("tmo_error_sticky", lock_error, 1);
      pll_auto = 1'b1;

      // Reset in GAP1 abandons the sequence; filter restarts and a fresh one follows
      bootleg = 1'b1;
      push_seq(KB, 0);
      base = n_done;
      for (int n = 0; n < 200 && n_done == base; n++) tick();
      check("rst_mid_mode_done", n_done - base, 1);
      reset = 1'b1;
      tick();
      check("rst_mid_write", bus.mgmt_write, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_profile", active_profile, 0);
      check("rst_mid_lock_error", lock_error, 0);
      exp_q.delete();
      push_seq(KB, 0);
      reset = 1'b0;
      drive = cyc;
      wait_profile(2'd2, "rst_fresh", at, hb);
      check("rst_fresh_latency", mode_start - drive, LAT);
      check("rst_fresh_settle", at - relock_cyc, 3 + SETTLE);

      tick(5);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pll_speed_ctrl.md
# pll_speed_ctrl

- Sequences Avalon-MM writes into the `pll_cfg` reconfiguration block so the 49 MHz core clock matches the requested speed profile: native, 60 Hz underclock, or bootleg.
- Sits directly upstream of `pll_cfg` in the `CLK_50M` domain.
- Filters the raw profile-select levels, performs the three-register reconfiguration, then waits for PLL relock before releasing a hold to the core.

## Interface

Parameters:
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required before a profile change is accepted.
- `GAP_CYCLES`, 3: idle cycles inserted after each accepted write.
- `LOCK_TIMEOUT`, 65535: maximum cycles spent in each lock-wait state.
- `SETTLE_CYCLES`, 1024: cycles after relock before the hold is released.
- `K_NATIVE`, 32'd3639383488: fractional-K word for the native profile.
- `K_UNDER`, 32'd2971430088: fractional-K word for the underclock profile.
- `K_BOOT`, 32'd2748778984: fractional-K word for the bootleg profile.

Ports:
- `clk_50m` in 1: management clock; all logic runs on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `underclock` in 1: asynchronous level, 1 = 60 Hz adjust requested.
- `bootleg` in 1: asynchronous level, 1 = bootleg timing requested; takes priority over `underclock`.
- `pll_locked` in 1: asynchronous PLL lock indicator.
- `mgmt_waitrequest` in 1: Avalon waitrequest from `pll_cfg`.
- `mgmt_write` out 1: Avalon write strobe.
- `mgmt_address` out 6: register address.
- `mgmt_writedata` out 32: register data.
- `busy` out 1: a reconfiguration is in progress.
- `core_hold` out 1: hold request to the core; high while the clock may be unstable.
- `lock_error` out 1: sticky flag, set when a lock-wait times out.
- `active_profile` out 2: profile last applied; 0 = native, 1 = underclock, 2 = bootleg.

## Operation

- **Input synchronization:** `underclock`, `bootleg` and `pll_locked` each pass through a 2-flop synchronizer.
- **Target profile:**
  - target = 2 if synced `bootleg`, else 1 if synced `underclock`, else 0.
  - A candidate counter restarts whenever target changes.
  - When target has been unchanged for `STABLE_CYCLES` consecutive cycles, it becomes the filtered target.
- **Request:** pending is set whenever filtered target ≠ `active_profile`. The request is taken in IDLE only.
- **States:**
  - IDLE: `busy`=0, `core_hold`=0. If pending, latch `req` = filtered target, then go to WR_MODE.
  - WR_MODE: address 0, data 0.
  - GAP1: count `GAP_CYCLES`.
  - WR_K: address 7, data = K word selected by `req`.
  - GAP2: count `GAP_CYCLES`.
  - WR_START: address 2, data 0.
  - WAIT_UNLOCK: leave when synced lock = 0, or on timeout.
  - WAIT_LOCK: leave when synced lock = 1, or on timeout.
  - SETTLE: count `SETTLE_CYCLES`; on exit, `active_profile` ← `req`, then IDLE.
- **Write states (Avalon rule):**
  - `mgmt_write`=1 with address and data stable until a cycle where `mgmt_waitrequest`=0; that cycle completes the transfer.
  - The next state is entered on the following edge.
  - Address and data return to 0 outside write states.
- **Timeouts:** either wait counter reaching `LOCK_TIMEOUT` sets `lock_error` and advances to the next state; a timeout never aborts the sequence.
- **Requests while busy:** a profile change during a sequence is not applied mid-sequence. After SETTLE, IDLE re-evaluates and starts a new sequence if filtered target ≠ `active_profile`.
- **Outputs during a sequence:** `busy`=1 and `core_hold`=1 in every state except IDLE.
- **Reset:**
  - Forces IDLE, all counters 0, `active_profile`=0, `lock_error`=0, and all outputs 0.
  - The PLL's power-on profile is native, so a non-zero target after reset triggers a sequence.
  - Reset mid-write drops `mgmt_write` on the next edge.

## Timing

- **Request latency:** the input edge appears as a synced level 2 cycles later. The filtered target updates after `STABLE_CYCLES` more cycles. WR_MODE is entered 1 cycle after that.
- **Minimum transaction:** with waitrequest held low, each write lasts exactly 1 cycle.
- **Nominal write schedule:** WR_MODE at cycle t, WR_K at t+1+`GAP_CYCLES`, WR_START at t+2+2·`GAP_CYCLES`.
- **Waitrequest stalls:** each cycle with waitrequest=1 extends the current write by 1 cycle.
- **Lock transitions:**
  - Synced lock edges lag `pll_locked` by 2 cycles.
  - WAIT_UNLOCK exits on the first cycle synced lock = 0.
  - WAIT_LOCK exits on the first cycle synced lock = 1.
- **Hold release:** `core_hold` falls on the same edge that `active_profile` updates.
- **Glitch rejection:** a target pulse shorter than `STABLE_CYCLES` produces no writes.

## Test plan

1. **Reset only:** `reset` for 3 cycles, inputs 0, PLL locked → no writes; `busy`=0, `active_profile`=0, `lock_error`=0 indefinitely.
2. **Underclock, no stalls:** `underclock`=1, waitrequest 0 → writes (0,0), (7,2971430088), (2,0) with 3 idle cycles between them. Then drop `pll_locked` 10 cycles, restore it → `active_profile`=1 exactly `SETTLE_CYCLES` cycles after synced relock.
3. **Bootleg priority plus stall:** `bootleg`=`underclock`=1, waitrequest high for 5 cycles during WR_K → K=2748778984; write held 6 cycles with address and data stable.
4. **Glitch and change while busy:**
   - 2-cycle `underclock` pulse → no writes.
   - Switching 1 → 0 while in WAIT_LOCK → a second sequence writes `K_NATIVE` right after the first settles.
5. **Timeouts:** `pll_locked` stuck at 1 with `LOCK_TIMEOUT`=16 → `lock_error`=1 after 16 WAIT_UNLOCK cycles; the sequence still completes and `lock_error` stays set.
6. **Reset mid-sequence:** `reset` during GAP1 → `mgmt_write`=0, IDLE, `active_profile`=0. Input still 1, so a fresh sequence starts after filtering.
